// File: rtl/odd_cnt_pkg.sv
// odd_cnt_pkg: shared state enum, default odd-counter constants and the next_odd sequence rule
package odd_cnt_pkg;
  typedef enum logic [1:0] {SYNC, ACQUIRE, LOCKED} state_t;
  localparam int CNT_W = 8;
  localparam int CNT_STEP = 2;
  localparam int CNT_WRAP = 1;
  function automatic logic [63:0] next_odd(input logic [63:0] v, input int w = CNT_W,
                                           input int step = CNT_STEP, input int wrap = CNT_WRAP);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return ((v & m) == m) ? 64'(wrap) : (v + 64'(step)) & m;
  endfunction
endpackage

// File: rtl/odd_cnt_checker_sat_counter.sv
// sat_counter: W-bit saturating up-counter; ports clk, reset, clear (zeroes, inc still counts), inc, cnt
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    cnt <= reset ? '0 : clear ? W'(inc) : (inc && cnt != '1) ? cnt + W'(1) : cnt;
endmodule

// File: rtl/odd_cnt_checker.sv
// odd_cnt_checker: odd-counter stream monitor; in clk/reset/valid_i/cnt_i/clear_i, out locked_o/err_o/err_cnt_o/expected_o
module odd_cnt_checker
  import odd_cnt_pkg::*;
#(
  parameter int WIDTH    = CNT_W,
  parameter int STEP     = CNT_STEP,
  parameter int WRAP_TO  = CNT_WRAP,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] cnt_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [WIDTH-1:0] expected_o
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  state_t state, state_n;
  logic [MW-1:0] match_q, match_n;
  logic [WIDTH-1:0] exp_n, nxt;
  logic good, err_n;
  assign nxt  = WIDTH'(next_odd(64'(cnt_i), WIDTH, STEP, WRAP_TO));
  assign good = valid_i && cnt_i[0] && cnt_i == expected_o;
  always_comb begin
    state_n = state;
    exp_n   = expected_o;
    match_n = match_q;
    err_n   = 1'b0;
    if (valid_i) begin
      case (state)
        SYNC: if (cnt_i[0]) begin
          state_n = ACQUIRE;
          exp_n   = nxt;
          match_n = MW'(1);
        end
        ACQUIRE: if (good) begin
          exp_n   = nxt;
          match_n = match_q + MW'(1);
          state_n = (match_q + MW'(1) == MW'(LOCK_CNT)) ? LOCKED : ACQUIRE;
        end else if (cnt_i[0]) begin
          exp_n   = nxt;
          match_n = MW'(1);
        end else begin
          state_n = SYNC;
          match_n = '0;
        end
        LOCKED: if (good) begin
          exp_n = nxt;
        end else begin
          err_n   = 1'b1;
          state_n = cnt_i[0] ? ACQUIRE : SYNC;
          exp_n   = cnt_i[0] ? nxt : expected_o;
          match_n = cnt_i[0] ? MW'(1) : '0;
        end
        default: state_n = SYNC;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    state      <= reset ? SYNC : state_n;
    expected_o <= reset ? WIDTH'(WRAP_TO) : exp_n;
    match_q    <= reset ? '0 : match_n;
    locked_o   <= reset ? 1'b0 : state_n == LOCKED;
    err_o      <= reset ? 1'b0 : err_n;
  end
  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk  (clk),
    .reset(reset),
    .clear(clear_i),
    .inc  (err_n),
    .cnt  (err_cnt_o)
  );
endmodule
